// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the 5-stage CPU pipeline registers.
//   ZERO_REG     - index of the hard-wired zero register at the default width
//   DATA_W_DEF   - default data channel width
//   RD_W_DEF     - default register index width
//   stage_ctrl_e - bit positions inside the control bundle
package pipe_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int RD_W_DEF   = 5;

  // All-ones register index is the zero register (XZR); never a forwarding source.
  localparam logic [RD_W_DEF-1:0] ZERO_REG = '1;

  typedef enum logic [1:0] {
    UNCOND_BR  = 2'd0,
    REG_WRITE  = 2'd1,
    MEM_TO_REG = 2'd2,
    MEM_WRITE  = 2'd3
  } stage_ctrl_e;

endpackage : pipe_pkg

// File: rtl/register_en_Nbit.sv
// register_en_Nbit: N-bit register with async active-low reset, synchronous
// clear and load enable. Clear has priority over enable; both return to RST_VAL.
//   clk    - rising-edge clock
//   rst_n  - asynchronous reset, active-low
//   en_i   - load d_i this edge
//   clr_i  - load RST_VAL this edge (overrides en_i)
//   d_i    - next value
//   q_o    - registered value
module register_en_Nbit #(
  parameter int             N       = 1,
  parameter logic [N-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;

  // NOTE: q_d takes the hold value first so every path assigns it and no latch is inferred.
  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = RST_VAL;
    end else if (en_i) begin
      q_d = d_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule : register_en_Nbit

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB).
// Carries valid, control bundle, NUM_DATA data channels and a destination
// register index, with stall (hold), flush (bubble), a saturating consecutive
// stall counter and a forwarding comparator against two consumer sources.
// Edge priority: flush > stall > load.
//   clk, reset          - clock, asynchronous active-low reset
//   stall, flush        - hold / bubble insertion
//   valid_in, ctrl_in, data_in, rd_in - upstream instruction
//   rs_a, rs_b          - consumer source register indices
//   valid_out, ctrl_out, data_out, rd_out - registered instruction
//   fwd_a, fwd_b        - forward this stage's result to source A / B
//   stall_cycles        - consecutive stalled cycles, saturating
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int NUM_DATA     = 2,
  parameter int CTRL_W       = 4,
  parameter int RD_W         = RD_W_DEF,
  parameter int REGWRITE_BIT = int'(REG_WRITE),
  parameter int CNT_W        = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       flush,
  input  logic                       valid_in,
  input  logic [CTRL_W-1:0]          ctrl_in,
  input  logic [NUM_DATA*DATA_W-1:0] data_in,
  input  logic [RD_W-1:0]            rd_in,
  input  logic [RD_W-1:0]            rs_a,
  input  logic [RD_W-1:0]            rs_b,
  output logic                       valid_out,
  output logic [CTRL_W-1:0]          ctrl_out,
  output logic [NUM_DATA*DATA_W-1:0] data_out,
  output logic [RD_W-1:0]            rd_out,
  output logic                       fwd_a,
  output logic                       fwd_b,
  output logic [CNT_W-1:0]           stall_cycles
);

  localparam logic [RD_W-1:0]  ZERO_RD = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                       valid_q;
  logic [CTRL_W-1:0]          ctrl_q;
  logic [CTRL_W-1:0]          ctrl_d;
  logic [NUM_DATA*DATA_W-1:0] data_q;
  logic [RD_W-1:0]            rd_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [CNT_W-1:0]           cnt_d;
  logic                       load_en;

  assign load_en = ~stall;

  // An invalid instruction never carries control into the next stage.
  assign ctrl_d = valid_in ? ctrl_in : '0;

  register_en_Nbit #(.N(1), .RST_VAL(1'b0)) u_valid_reg (
    .clk   (clk),
    .rst_n (reset),
    .en_i  (load_en),
    .clr_i (flush),
    .d_i   (valid_in),
    .q_o   (valid_q)
  );

  register_en_Nbit #(.N(CTRL_W), .RST_VAL('0)) u_ctrl_reg (
    .clk   (clk),
    .rst_n (reset),
    .en_i  (load_en),
    .clr_i (flush),
    .d_i   (ctrl_d),
    .q_o   (ctrl_q)
  );

  // Data is left untouched by a flush: the bubble is defined by valid/ctrl/rd alone.
  register_en_Nbit #(.N(NUM_DATA*DATA_W), .RST_VAL('0)) u_data_reg (
    .clk   (clk),
    .rst_n (reset),
    .en_i  (load_en & ~flush),
    .clr_i (1'b0),
    .d_i   (data_in),
    .q_o   (data_q)
  );

  register_en_Nbit #(.N(RD_W), .RST_VAL(ZERO_RD)) u_rd_reg (
    .clk   (clk),
    .rst_n (reset),
    .en_i  (load_en),
    .clr_i (flush),
    .d_i   (rd_in),
    .q_o   (rd_q)
  );

  // Consecutive stall counter: saturates instead of wrapping, clears on flush or load.
  always_comb begin
    cnt_d = '0;
    if (!flush && stall) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Writes to the zero register are discarded, so they must never be forwarded.
  logic producer_ok;
  assign producer_ok = valid_q & ctrl_q[REGWRITE_BIT] & (rd_q != ZERO_RD);
  assign fwd_a       = producer_ok & (rd_q == rs_a);
  assign fwd_b       = producer_ok & (rd_q == rs_b);

  assign valid_out    = valid_q;
  assign ctrl_out     = ctrl_q;
  assign data_out     = data_q;
  assign rd_out       = rd_q;
  assign stall_cycles = cnt_q;

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg with default parameters.
// A reference model computes the expected stage contents whenever stimulus is
// driven; the expectation is queued and compared after the next clock edge.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DW = 64;
  localparam int ND = 2;
  localparam int CW = 4;
  localparam int RW = 5;
  localparam int KW = 4;

  typedef struct {
    logic           v;
    logic [CW-1:0]  ctrl;
    logic [ND*DW-1:0] data;
    logic [RW-1:0]  rd;
    logic [KW-1:0]  cnt;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              stall, flush, valid_in;
  logic [CW-1:0]     ctrl_in;
  logic [ND*DW-1:0]  data_in;
  logic [RW-1:0]     rd_in, rs_a, rs_b;
  logic              valid_out, fwd_a, fwd_b;
  logic [CW-1:0]     ctrl_out;
  logic [ND*DW-1:0]  data_out;
  logic [RW-1:0]     rd_out;
  logic [KW-1:0]     stall_cycles;

  int checks   = 0;
  int failures = 0;

  exp_t model;
  exp_t sb_q[$];

  pipe_stage_reg dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .flush        (flush),
    .valid_in     (valid_in),
    .ctrl_in      (ctrl_in),
    .data_in      (data_in),
    .rd_in        (rd_in),
    .rs_a         (rs_a),
    .rs_b         (rs_b),
    .valid_out    (valid_out),
    .ctrl_out     (ctrl_out),
    .data_out     (data_out),
    .rd_out       (rd_out),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic exp_t reset_state();
    exp_t e;
    e.v    = 1'b0;
    e.ctrl = '0;
    e.data = '0;
    e.rd   = ZERO_REG;
    e.cnt  = '0;
    return e;
  endfunction

  // Compare every DUT output against an expected stage state.
  task automatic compare_all(input string tag, input exp_t e);
    logic ea, eb;
    ea = e.v & e.ctrl[1] & (e.rd == rs_a) & (e.rd != 5'd31);
    eb = e.v & e.ctrl[1] & (e.rd == rs_b) & (e.rd != 5'd31);
    check({tag, ".valid"}, 128'(valid_out), 128'(e.v));
    check({tag, ".ctrl"},  128'(ctrl_out),  128'(e.ctrl));
    check({tag, ".data"},  data_out,        e.data);
    check({tag, ".rd"},    128'(rd_out),    128'(e.rd));
    check({tag, ".cnt"},   128'(stall_cycles), 128'(e.cnt));
    check({tag, ".fwd_a"}, 128'(fwd_a),     128'(ea));
    check({tag, ".fwd_b"}, 128'(fwd_b),     128'(eb));
  endtask

  // Drive one cycle of stimulus, push the model's expectation, then pop and
  // compare once the DUT has taken the edge.
  task automatic cycle(input string tag, input logic st, input logic fl, input logic v,
                       input logic [CW-1:0] c, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic [RW-1:0] r, input logic [RW-1:0] ra, input logic [RW-1:0] rb);
    exp_t e;
    stall = st; flush = fl; valid_in = v; ctrl_in = c;
    data_in = {d1, d0}; rd_in = r; rs_a = ra; rs_b = rb;
    if (fl) begin
      model.v = 1'b0; model.ctrl = '0; model.rd = 5'd31; model.cnt = '0;
    end else if (st) begin
      if (model.cnt != 4'd15) model.cnt = model.cnt + 4'd1;
    end else begin
      model.v    = v;
      model.ctrl = v ? c : 4'd0;
      model.data = {d1, d0};
      model.rd   = r;
      model.cnt  = '0;
    end
    sb_q.push_back(model);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s: scoreboard empty got 0 expected 1", tag);
    end else begin
      e = sb_q.pop_front();
      compare_all(tag, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with live inputs: outputs must stay at reset values.
    reset = 1'b0; stall = 1'b0; flush = 1'b0; valid_in = 1'b1;
    ctrl_in = 4'b0010; data_in = 128'hDEAD; rd_in = 5'd31; rs_a = 5'd31; rs_b = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    model = reset_state();
    compare_all("reset", model);
    check("reset.rd_const", 128'(rd_out), 128'd31);
    @(negedge clk);
    reset = 1'b1;

    // Plain load and forwarding.
    cycle("load", 1'b0, 1'b0, 1'b1, 4'b0010, 64'h10, 64'h20, 5'd5, 5'd5, 5'd6);
    check("load.fwd_a_const", 128'(fwd_a), 128'd1);
    check("load.data_const", data_out, {64'h20, 64'h10});

    // Long stall with changing inputs: frozen outputs, saturating counter.
    for (int i = 0; i < 20; i++) begin
      cycle("stall", 1'b1, 1'b0, 1'b1, 4'($urandom_range(0, 15)), 64'($urandom()),
            64'($urandom()), 5'(i), 5'd5, 5'd6);
      check("stall.cnt_const", 128'(stall_cycles), 128'((i + 1 > 15) ? 15 : i + 1));
    end

    // Stall released: new instruction loads and the counter clears.
    cycle("unstall", 1'b0, 1'b0, 1'b1, 4'b0010, 64'hAAAA, 64'hBBBB, 5'd7, 5'd0, 5'd7);
    check("unstall.cnt_const", 128'(stall_cycles), 128'd0);

    // Build the counter up, then flush and stall together.
    cycle("pre_fl", 1'b1, 1'b0, 1'b0, 4'h0, 64'h1, 64'h2, 5'd1, 5'd7, 5'd7);
    cycle("pre_fl", 1'b1, 1'b0, 1'b0, 4'h0, 64'h1, 64'h2, 5'd1, 5'd7, 5'd7);
    cycle("flush_stall", 1'b1, 1'b1, 1'b1, 4'hF, 64'h3, 64'h4, 5'd9, 5'd7, 5'd7);
    check("flush.data_kept", data_out, {64'hBBBB, 64'hAAAA});
    check("flush.fwd_b_const", 128'(fwd_b), 128'd0);

    // Invalid instruction never carries control.
    cycle("invalid", 1'b0, 1'b0, 1'b0, 4'hF, 64'h5, 64'h6, 5'd3, 5'd3, 5'd3);
    check("invalid.ctrl_const", 128'(ctrl_out), 128'd0);

    // Writes to the zero register are not forwarded.
    cycle("xzr", 1'b0, 1'b0, 1'b1, 4'b0010, 64'h7, 64'h8, 5'd31, 5'd31, 5'd31);
    check("xzr.fwd_a_const", 128'(fwd_a), 128'd0);

    // RegWrite clear: no forwarding even when indices match.
    cycle("no_rw", 1'b0, 1'b0, 1'b1, 4'b1101, 64'h9, 64'hA, 5'd12, 5'd12, 5'd12);

    // Random mix of stall / flush / load.
    for (int i = 0; i < 40; i++) begin
      logic [RW-1:0] r;
      r = 5'($urandom_range(0, 31));
      cycle("random", 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 5) == 0),
            1'($urandom()), 4'($urandom()), 64'($urandom()), 64'($urandom()), r,
            ($urandom_range(0, 1) == 1) ? r : 5'($urandom()), 5'($urandom()));
    end

    // Asynchronous reset between edges while a valid instruction is held.
    cycle("pre_arst", 1'b0, 1'b0, 1'b1, 4'b0010, 64'hC, 64'hD, 5'd4, 5'd4, 5'd4);
    cycle("pre_arst", 1'b1, 1'b0, 1'b1, 4'b0010, 64'hE, 64'hF, 5'd8, 5'd4, 5'd4);
    #2;
    reset = 1'b0;
    #1;
    model = reset_state();
    compare_all("async_rst", model);
    @(negedge clk);
    reset = 1'b1;
    cycle("post_arst", 1'b0, 1'b0, 1'b1, 4'b0010, 64'h11, 64'h22, 5'd2, 5'd2, 5'd1);

    if (sb_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL sb_drain: got %0d expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pipe_stage_reg
